maquina_estados_param: RTL and testbench

MAQUINA_ESTADOS_PARAM -- requirements
Module: maquina_estados_param

---
 rtl/maquina_estados_pkg.sv | 15 +
 rtl/maquina_estados_param_contador_idle.sv | 38 +++
 rtl/maquina_estados_param.sv | 122 ++++++++++++
 tb/tb_maquina_estados_param.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/maquina_estados_pkg.sv
// Shared state encoding and default widths for the maquina_estados FSM.
package maquina_estados_pkg;

   localparam int ESTADO_W     = 3;
   localparam int UMBRAL_W_DEF = 3;

   typedef enum logic [ESTADO_W-1:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } estado_t;

endpackage

// File: rtl/maquina_estados_param_contador_idle.sv
// Consecutive all-empty cycle counter; done flags the edge where the count would reach IDLE_CNT.
module contador_idle #(
   parameter int IDLE_CNT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic done
);

   localparam int CNT_W = $clog2(IDLE_CNT + 1);
   localparam logic [CNT_W-1:0] TERM = CNT_W'(IDLE_CNT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign done = en && (cnt_q == TERM);

   // Terminal count clears instead of incrementing, so the counter never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clr || done) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/maquina_estados_param.sv
// FIFO activity state machine with threshold configuration; UMBRAL_CHECK_EN enables bajo>alto rejection.
//
// state     | meaning
// RESET  0  | held in reset, leaves on first edge with reset high
// INIT   1  | capturing thresholds into shadows while init=1
// IDLE   2  | all FIFOs empty, waiting for activity
// ACTIVE 3  | some FIFO busy, counting consecutive all-empty cycles
// ERROR  4  | rejected thresholds, only init or reset leave
module maquina_estados_param
   import maquina_estados_pkg::*;
#(
   parameter int NUM_FIFOS = 8,
   parameter int UMBRAL_W  = UMBRAL_W_DEF,
   parameter int IDLE_CNT  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                init,
   input  logic [UMBRAL_W-1:0] bajo,
   input  logic [UMBRAL_W-1:0] alto,
   input  logic [NUM_FIFOS-1:0] empty_fifos,
   output logic [ESTADO_W-1:0] estado_out,
   output logic                active_out,
   output logic                idle_out,
   output logic                error_out,
   output logic [UMBRAL_W-1:0] bajo_out,
   output logic [UMBRAL_W-1:0] alto_out
);

   estado_t             estado_q;
   estado_t             estado_d;
   logic [UMBRAL_W-1:0] sh_bajo_q;
   logic [UMBRAL_W-1:0] sh_alto_q;
   logic [UMBRAL_W-1:0] bajo_q;
   logic [UMBRAL_W-1:0] alto_q;
   logic                active_q;
   logic                idle_q;
   logic                all_empty;
   logic                cnt_en;
   logic                cnt_clr;
   logic                cnt_done;
   logic                umbral_mal;

   assign all_empty = &empty_fifos;
   assign cnt_en    = (estado_q == ST_ACTIVE) && !init && all_empty;
   assign cnt_clr   = (estado_q != ST_ACTIVE) || init || !all_empty;

`ifdef UMBRAL_CHECK_EN
   logic error_q;
   assign umbral_mal = (sh_bajo_q > sh_alto_q);
   assign error_out  = error_q;
`else
   assign umbral_mal = 1'b0;
   assign error_out  = 1'b0;
`endif

   contador_idle #(
      .IDLE_CNT (IDLE_CNT)
   ) u_contador_idle (
      .clk   (clk),
      .reset (reset),
      .en    (cnt_en),
      .clr   (cnt_clr),
      .done  (cnt_done)
   );

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         ST_RESET:  estado_d = ST_INIT;
         ST_INIT:   if (!init) estado_d = umbral_mal ? ST_ERROR : ST_IDLE;
         ST_IDLE: begin
            if (init)            estado_d = ST_INIT;
            else if (!all_empty) estado_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (init)          estado_d = ST_INIT;
            else if (cnt_done) estado_d = ST_IDLE;
         end
         ST_ERROR:  if (init) estado_d = ST_INIT;
         default:   estado_d = ST_RESET;
      endcase
   end

   // Status flags decode the next state so they line up with estado_q.
   always_ff @(posedge clk) begin
      if (!reset) begin
         estado_q  <= ST_RESET;
         active_q  <= 1'b0;
         idle_q    <= 1'b0;
         sh_bajo_q <= '0;
         sh_alto_q <= '0;
         bajo_q    <= '0;
         alto_q    <= '0;
`ifdef UMBRAL_CHECK_EN
         error_q   <= 1'b0;
`endif
      end else begin
         estado_q <= estado_d;
         active_q <= (estado_d == ST_ACTIVE);
         idle_q   <= (estado_d == ST_IDLE);
`ifdef UMBRAL_CHECK_EN
         error_q  <= (estado_d == ST_ERROR);
`endif
         if (estado_q == ST_INIT && init) begin
            sh_bajo_q <= bajo;
            sh_alto_q <= alto;
         end
         if (estado_q == ST_INIT && !init && !umbral_mal) begin
            bajo_q <= sh_bajo_q;
            alto_q <= sh_alto_q;
         end
      end
   end

   assign estado_out = estado_q;
   assign active_out = active_q;
   assign idle_out   = idle_q;
   assign bajo_out   = bajo_q;
   assign alto_out   = alto_q;

endmodule

// File: tb/tb_maquina_estados_param.sv
// Directed bench for maquina_estados_param; expectations follow UMBRAL_CHECK_EN when defined.
module tb_maquina_estados_param;

   logic       clk = 1'b0;
   logic       reset;
   logic       init;
   logic [2:0] bajo;
   logic [2:0] alto;
   logic [7:0] empty_fifos;
   logic [2:0] estado_out;
   logic       active_out;
   logic       idle_out;
   logic       error_out;
   logic [2:0] bajo_out;
   logic [2:0] alto_out;

   int vecs = 0;
   int errs = 0;

   maquina_estados_param #(
      .NUM_FIFOS (8),
      .UMBRAL_W  (3),
      .IDLE_CNT  (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .init        (init),
      .bajo        (bajo),
      .alto        (alto),
      .empty_fifos (empty_fifos),
      .estado_out  (estado_out),
      .active_out  (active_out),
      .idle_out    (idle_out),
      .error_out   (error_out),
      .bajo_out    (bajo_out),
      .alto_out    (alto_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input logic [2:0] st);
      chk({tag, ".estado"}, 32'(estado_out), 32'(st));
      chk({tag, ".active"}, 32'(active_out), 32'(st == 3'd3));
      chk({tag, ".idle"},   32'(idle_out),   32'(st == 3'd2));
      chk({tag, ".error"},  32'(error_out),  32'(st == 3'd4));
   endtask

   task automatic chk_thr(input string tag, input logic [2:0] b, input logic [2:0] a);
      chk({tag, ".bajo_out"}, 32'(bajo_out), 32'(b));
      chk({tag, ".alto_out"}, 32'(alto_out), 32'(a));
   endtask

   initial begin
      reset = 1'b0; init = 1'b0; bajo = 3'd0; alto = 3'd0; empty_fifos = 8'hFF;
      #1;
      // reset scenario
      tick(); tick();
      chk_st("rst_hold", 3'd0);
      chk_thr("rst_hold", 3'd0, 3'd0);
      reset = 1'b1;
      tick(); chk_st("rst_rel1", 3'd1);
      tick(); chk_st("rst_rel2", 3'd2);
      tick(); chk_st("rst_rel3", 3'd2);

      // init scenario
      init = 1'b1; bajo = 3'd2; alto = 3'd5;
      tick(); chk_st("init_enter", 3'd1); chk_thr("init_enter", 3'd0, 3'd0);
      tick(); tick(); chk_thr("init_hold", 3'd0, 3'd0);
      init = 1'b0; bajo = 3'd7; alto = 3'd7;
      tick(); chk_st("init_exit", 3'd2); chk_thr("init_exit", 3'd2, 3'd5);

      // simultaneous init and activity in IDLE
      init = 1'b1; empty_fifos = 8'h00;
      tick(); chk_st("simul", 3'd1);
      init = 1'b0; empty_fifos = 8'hFF;
      tick(); chk_st("simul_exit", 3'd2); chk_thr("simul_exit", 3'd2, 3'd5);

      // debounce: plain count
      empty_fifos = 8'hFE;
      tick(); chk_st("deb_act", 3'd3);
      empty_fifos = 8'hFF;
      tick(); chk_st("deb_e1", 3'd3);
      tick(); chk_st("deb_e2", 3'd3);
      tick(); chk_st("deb_e3", 3'd3);
      tick(); chk_st("deb_e4", 3'd2);

      // debounce: glitch on third all-empty edge restarts the count
      empty_fifos = 8'hFE;
      tick(); chk_st("gl_act", 3'd3);
      empty_fifos = 8'hFF;
      tick(); tick();
      empty_fifos = 8'h7F;
      tick(); chk_st("gl_glitch", 3'd3);
      empty_fifos = 8'hFF;
      tick(); tick(); tick(); chk_st("gl_e3", 3'd3);
      tick(); chk_st("gl_e4", 3'd2);

      // mid-operation reset with counter at 2
      empty_fifos = 8'hFE;
      tick(); chk_st("mr_act", 3'd3);
      empty_fifos = 8'hFF;
      tick(); tick();
      reset = 1'b0;
      tick(); chk_st("mr_rst", 3'd0); chk_thr("mr_rst", 3'd0, 3'd0);
      reset = 1'b1;
      tick(); chk_st("mr_rel1", 3'd1);
      tick(); chk_st("mr_rel2", 3'd2); chk_thr("mr_rel2", 3'd0, 3'd0);
      empty_fifos = 8'hFE;
      tick(); chk_st("mr_act2", 3'd3);
      empty_fifos = 8'hFF;
      tick(); tick(); tick(); chk_st("mr_e3", 3'd3);
      tick(); chk_st("mr_e4", 3'd2);

      // threshold check: good config first, then bajo > alto
      init = 1'b1; bajo = 3'd3; alto = 3'd4;
      tick(); tick();
      init = 1'b0;
      tick(); chk_st("thr_good", 3'd2); chk_thr("thr_good", 3'd3, 3'd4);
      init = 1'b1; bajo = 3'd6; alto = 3'd1;
      tick(); tick();
      init = 1'b0;
      tick();
`ifdef UMBRAL_CHECK_EN
      chk_st("thr_bad", 3'd4); chk_thr("thr_bad", 3'd3, 3'd4);
      empty_fifos = 8'h00;
      tick(); chk_st("thr_err_hold", 3'd4);
      empty_fifos = 8'hFF;
`else
      chk_st("thr_bad", 3'd2); chk_thr("thr_bad", 3'd6, 3'd1);
`endif
      init = 1'b1; bajo = 3'd1; alto = 3'd6;
      tick(); chk_st("thr_reinit", 3'd1);
      tick();
      init = 1'b0;
      tick(); chk_st("thr_final", 3'd2); chk_thr("thr_final", 3'd1, 3'd6);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
